// File: rtl/display_scan.sv
// display_scan: multiplexed display scanner.
//
// Steps through the enabled display positions, dwelling SCAN_DIV clocks on
// each one. For the position being driven it presents a registered digit code
// and an active-low strobe. Positions selected by blink_mask go dark during
// the off half of a slow blink cycle.
//
// Ports
//   clk         in   1                  rising-edge clock
//   rst         in   1                  synchronous, active-high reset
//   en          in   1                  1 = scan runs; 0 = counters hold, strobes off
//   load        in   1                  capture dig into the shadow register
//   dig         in   DIGITS*CODE_W      packed codes, digit k at [k*CODE_W +: CODE_W]
//   digit_en    in   DIGITS             positions that take part in the scan
//   blink_mask  in   DIGITS             positions that blank in the blink-off phase
//   num         out  NUM_W              index of the currently driven position
//   code        out  CODE_W             registered code of the driven position
//   an          out  DIGITS             active-low position strobe, one-hot low
//   frame_done  out  1                  one-cycle pulse when num wraps to the lowest position
module display_scan #(
    parameter int DIGITS    = 8,
    parameter int CODE_W    = 5,
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 64,
    localparam int NUM_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     load,
    input  logic [DIGITS*CODE_W-1:0] dig,
    input  logic [DIGITS-1:0]        digit_en,
    input  logic [DIGITS-1:0]        blink_mask,
    output logic [NUM_W-1:0]         num,
    output logic [CODE_W-1:0]        code,
    output logic [DIGITS-1:0]        an,
    output logic                     frame_done
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

    logic [PRE_W-1:0]         pre_cnt;
    logic [BLK_W-1:0]         blk_cnt;
    logic                     blink_phase;
    logic [DIGITS*CODE_W-1:0] shadow;
    logic [DIGITS-1:0]        an_r;
    logic                     tick;

    logic                     above_found;
    logic [NUM_W-1:0]         above_idx;
    logic [NUM_W-1:0]         lowest_idx;
    logic [4:0]               en_count;
    logic                     any_en;
    logic                     wrap;
    logic [NUM_W-1:0]         num_next;
    logic [CODE_W-1:0]        cur_code;
    logic [DIGITS-1:0]        an_sel;

    assign tick = en & (pre_cnt == PRE_MAX);

    // Prescaler and blink counter both freeze while en is low, so a resume
    // continues the interrupted dwell exactly where it stopped.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt     <= '0;
            blk_cnt     <= '0;
            blink_phase <= 1'b0;
        end else if (en) begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                if (blk_cnt == BLK_MAX) begin
                    blk_cnt     <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blk_cnt <= blk_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= dig;
        end
    end

    // Scanning from the top down leaves the lowest enabled position in
    // lowest_idx and the lowest enabled position above num in above_idx.
    // With only num itself enabled the search lands back on num.
    always_comb begin
        above_found = 1'b0;
        above_idx   = '0;
        lowest_idx  = '0;
        en_count    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (digit_en[k]) begin
                lowest_idx = NUM_W'(k);
                en_count   = en_count + 5'd1;
                if (k > int'(num)) begin
                    above_found = 1'b1;
                    above_idx   = NUM_W'(k);
                end
            end
        end
    end

    assign any_en   = |digit_en;
    // A wrap only counts as a frame when at least two positions take part.
    assign wrap     = ~above_found & (en_count >= 5'd2);
    assign num_next = above_found ? above_idx : (any_en ? lowest_idx : num);

    always_comb begin
        cur_code = shadow[int'(num)*CODE_W +: CODE_W];
        an_sel   = '1;
        if (digit_en[num] && !(blink_phase && blink_mask[num])) begin
            an_sel[num] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num        <= '0;
            code       <= '0;
            an_r       <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= tick & wrap;
            if (tick) begin
                num <= num_next;
            end
            code <= any_en ? cur_code : '0;
            an_r <= an_sel;
        end
    end

    // Strobes are cut immediately when scanning is disabled.
    assign an = en ? an_r : '1;

endmodule

// File: tb/tb_display_scan.sv
module tb_display_scan;

    localparam int DIGITS    = 4;
    localparam int CODE_W    = 5;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;

    localparam logic [19:0] D1 = {5'h13, 5'h02, 5'h11, 5'h00};
    localparam logic [19:0] D2 = {5'h1F, 5'h0A, 5'h15, 5'h07};

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [19:0] dig;
    logic [3:0]  digit_en;
    logic [3:0]  blink_mask;
    logic [1:0]  num;
    logic [4:0]  code;
    logic [3:0]  an;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    display_scan #(
        .DIGITS    (DIGITS),
        .CODE_W    (CODE_W),
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .dig        (dig),
        .digit_en   (digit_en),
        .blink_mask (blink_mask),
        .num        (num),
        .code       (code),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       load;
        logic [3:0] de;
        logic [3:0] bm;
        int         ncyc;
        logic [1:0] e_num;
        logic [4:0] e_code;
        logic [3:0] e_an;
        logic       e_fd;
    } vec_t;

    vec_t vecs [20];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_num, input logic [4:0] e_code,
                           input logic [3:0] e_an, input logic e_fd);
        chk({tag, " num"}, 32'(num), 32'(e_num));
        chk({tag, " code"}, 32'(code), 32'(e_code));
        chk({tag, " an"}, 32'(an), 32'(e_an));
        chk({tag, " frame_done"}, 32'(frame_done), 32'(e_fd));
    endtask

    initial begin
        int fd_cnt;

        //          en    load  de       bm       n  num   code   an       fd
        vecs[0]  = '{1'b1, 1'b1, 4'b1111, 4'b0000, 1, 2'd0, 5'h00, 4'b1110, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 4, 2'd1, 5'h11, 4'b1101, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 4, 2'd2, 5'h02, 4'b1011, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 4, 2'd3, 5'h13, 4'b0111, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 3, 2'd0, 5'h13, 4'b0111, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 1, 2'd0, 5'h00, 4'b1110, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 4'b0101, 4'b0000, 4, 2'd2, 5'h02, 4'b1011, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 4'b0101, 4'b0000, 3, 2'd0, 5'h02, 4'b1011, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 4'b0101, 4'b0000, 1, 2'd0, 5'h00, 4'b1110, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 4'b1111, 4'b0010, 4, 2'd1, 5'h11, 4'b1111, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 4'b1111, 4'b0010, 4, 2'd2, 5'h02, 4'b1011, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 4'b1111, 4'b0010, 8, 2'd0, 5'h00, 4'b1110, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 4'b1111, 4'b0010, 4, 2'd1, 5'h11, 4'b1111, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 4'b1111, 4'b0010, 4, 2'd2, 5'h02, 4'b1011, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 4'b0100, 4'b0000, 3, 2'd2, 5'h02, 4'b1011, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 4'b1011, 4'b0000, 1, 2'd2, 5'h02, 4'b1111, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 4'b1011, 4'b0000, 3, 2'd3, 5'h02, 4'b1111, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 4'b1011, 4'b0000, 1, 2'd3, 5'h13, 4'b0111, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1, 2'd3, 5'h00, 4'b1111, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 6, 2'd3, 5'h00, 4'b1111, 1'b0};

        rst        = 1'b1;
        en         = 1'b0;
        load       = 1'b0;
        dig        = '0;
        digit_en   = '0;
        blink_mask = '0;
        step();
        step();
        chk_all("reset", 2'd0, 5'h00, 4'b1111, 1'b0);

        rst = 1'b0;
        dig = D1;
        for (int i = 0; i < 20; i++) begin
            en         = vecs[i].en;
            load       = vecs[i].load;
            digit_en   = vecs[i].de;
            blink_mask = vecs[i].bm;
            repeat (vecs[i].ncyc) step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_num, vecs[i].e_code,
                    vecs[i].e_an, vecs[i].e_fd);
        end

        // Frame rate: all four enabled, then two enabled.
        digit_en = 4'b1111;
        fd_cnt   = 0;
        for (int c = 0; c < 32; c++) begin
            step();
            if (frame_done === 1'b1) fd_cnt++;
        end
        chk("frames_4pos_32cyc", 32'(fd_cnt), 32'd2);
        chk("num_after_4pos", 32'(num), 32'd3);

        digit_en = 4'b0101;
        fd_cnt   = 0;
        for (int c = 0; c < 32; c++) begin
            step();
            if (frame_done === 1'b1) fd_cnt++;
        end
        chk("frames_2pos_32cyc", 32'(fd_cnt), 32'd4);
        chk("num_after_2pos", 32'(num), 32'd2);

        // Drop en mid-dwell for 10 cycles, then resume the remaining dwell.
        digit_en = 4'b1111;
        step();
        step();
        chk("pre_pause_an", 32'(an), 32'(4'b1011));
        en = 1'b0;
        step();
        chk("paused_an_first", 32'(an), 32'(4'b1111));
        repeat (9) step();
        chk("paused_an_last", 32'(an), 32'(4'b1111));
        chk("paused_num", 32'(num), 32'd2);
        en = 1'b1;
        step();
        chk("resume_num_hold", 32'(num), 32'd2);
        chk("resume_an", 32'(an), 32'(4'b1011));
        step();
        chk("resume_num_adv", 32'(num), 32'd3);

        // Load on the tick cycle; the wrapped position shows the new data.
        repeat (3) step();
        load = 1'b1;
        dig  = D2;
        step();
        load = 1'b0;
        chk("ldtick_num", 32'(num), 32'd0);
        chk("ldtick_fd", 32'(frame_done), 32'd1);
        chk("ldtick_code_old", 32'(code), 32'h13);
        step();
        chk("ldtick_code_new", 32'(code), 32'h07);
        chk("ldtick_an", 32'(an), 32'(4'b1110));
        digit_en = 4'b0000;
        step();
        chk("none_en_an", 32'(an), 32'(4'b1111));
        chk("none_en_code", 32'(code), 32'h00);

        // Reset mid-frame at num=3, with load asserted alongside.
        digit_en = 4'b1111;
        repeat (11) step();
        chk("prerst_num", 32'(num), 32'd3);
        chk("prerst_code", 32'(code), 32'h1F);
        rst  = 1'b1;
        load = 1'b1;
        dig  = D2;
        step();
        chk_all("midrst", 2'd0, 5'h00, 4'b1111, 1'b0);
        rst  = 1'b0;
        load = 1'b0;
        step();
        chk("postrst_code_cleared", 32'(code), 32'h00);
        chk("postrst_an", 32'(an), 32'(4'b1110));
        step();
        step();
        chk("first_tick_not_yet", 32'(num), 32'd0);
        step();
        chk("first_tick_num", 32'(num), 32'd1);

        // Reset with position 0 disabled: num starts at 0, first tick goes to 2.
        rst = 1'b1;
        step();
        rst      = 1'b0;
        digit_en = 4'b1100;
        step();
        chk("rst_de1100_num", 32'(num), 32'd0);
        chk("rst_de1100_an", 32'(an), 32'(4'b1111));
        repeat (3) step();
        chk("rst_de1100_tick_num", 32'(num), 32'd2);
        chk("rst_de1100_fd", 32'(frame_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
